pp_reduce_pipe: RTL
===================

Name: pp_reduce_pipe

Overview:
- Parametrised, pipelined successor to the 17-row partial-product reduction tree.
- Reduces NPP=17 partial-product rows of width W to a redundant SUM/CARRY pair. Ordering: four 4:2 groups, a 3:2 merge of row 16, then two 4:2 levels.
- Wraps the tree in an elastic valid/ready pipeline with per-level register insertion and a sideband tag.
- Sits between the Booth/PP generator and the final CPA of the multiplier datapath.

Parameters:
W, 64, row width in bits; all arithmetic is modulo 2^W.
TAG_W, 4, width of sideband tag carried alongside each operand set.
PIPE_MASK, 4'b0101, bit k=1 inserts a register after tree level k. Levels: 0 = 4:2 x4, 1 = 3:2 merge, 2 = 4:2 x2, 3 = final 4:2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operand set this cycle
in_pp  input  17*W  rows P0..P16; Pi = in_pp[i*W +: W]
in_tag  input  TAG_W  sideband, returned unchanged with result
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  W  final sum row
out_carry  output  W  final carry row, weight <<1 (bit W-1 shifted out)
out_tag  output  TAG_W  tag of the result

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Invariant on every accepted set: out_sum + (out_carry << 1) == sum(P0..P16) mod 2^W.
- Every inter-level carry row is shifted left by 1 before the next level, with bit W-1 discarded.
- The 4:2 cell chains its cout into the next bit's cin, with bit 0 seeded with 0.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Each enabled register stage k holds data plus a valid bit v_k and an elastic ready: rdy_k = !v_k || rdy_{k+1}, where rdy of the last stage = out_ready.
- in_ready = rdy of the first enabled stage. With PIPE_MASK=0, in_ready = out_ready and the path is fully combinational.
- Latency L = popcount(PIPE_MASK) cycles from accept to out_valid, when out_ready is held high.
- Throughput: one set per cycle, no bubbles, when out_ready is held high.
- Stall: when rdy_{k+1}=0 and v_k=1, stage k holds data, tag and valid unchanged. Stages may fill behind a stalled stage: a bubble (v=0) accepts new data even while downstream is stalled.
- Outputs are stable while out_valid && !out_ready (no data change, no valid drop).
- Reset: all v_k cleared; out_valid=0; out_sum, out_carry, out_tag = 0; in_ready=1 in the cycle after rst deasserts (it is combinational from valids).
- Reset mid-operation: in-flight sets are discarded, not flushed to the output. Inputs presented during rst are ignored.
- Data registers reset to 0, so no X is ever visible on the outputs.
- Simultaneous accept and emit on a full pipeline is permitted. Occupancy never exceeds popcount(PIPE_MASK).

Optional Feature:
- Macro: PP_REDUCE_CPA_EN.
- Defined:
  - Adds output port out_prod [W-1:0] = out_sum + (out_carry << 1) mod 2^W.
  - The addition is computed in one extra elastic register stage at the tail, so L = popcount(PIPE_MASK) + 1.
  - out_prod resets to 0 and obeys the same hold/stall rules.
- Undefined: no out_prod port, no extra stage; latency as above.

Test Plan:
- W=64, PIPE_MASK=4'b0101: single set with all Pi=1, tag=3 -> after 2 cycles out_valid=1, out_sum+(out_carry<<1)=17, out_tag=3.
- All Pi=64'hFFFF_FFFF_FFFF_FFFF -> reconstructed value = 2^64-17 = 64'hFFFF_FFFF_FFFF_FFEF; out_prod equals this when PP_REDUCE_CPA_EN is defined.
- 100 back-to-back random sets with out_ready=1 -> in_ready stays 1, outputs arrive in order at 1/cycle, each matching a reference modulo sum and its tag.
- out_ready=0 for 5 cycles while streaming -> pipeline fills to 2 entries, in_ready drops to 0, out_sum/out_carry/out_tag stable. After release, no set is lost or duplicated.
- rst asserted for 1 cycle with 2 sets in flight -> next cycle out_valid=0, outputs 0, in_ready=1, and neither discarded set ever appears.
- PIPE_MASK=4'b0000 and 4'b1111 -> latency 0 and 4 respectively; same random vectors give bit-identical out_sum/out_carry.

Source files
------------

// File: rtl/pp_reduce_pipe.sv
// 17-row partial-product reduction tree in an elastic valid/ready pipeline, with a tag sideband.
// Define PP_REDUCE_CPA_EN to add out_prod, the carry-propagate sum computed in one extra registered tail stage.

module pp_reduce_c42 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-1:0] s1;
  logic [W-1:0] cin;

  assign cin[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s1[i]    = a[i] ^ b[i] ^ c[i];
    assign sum[i]   = s1[i] ^ d[i] ^ cin[i];
    assign carry[i] = (s1[i] & d[i]) | (s1[i] & cin[i]) | (d[i] & cin[i]);
    // The cout of the MSB has weight 2^W and drops out of the modulo result.
    if (i < W-1) begin : g_cout
      assign cin[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end
endmodule

module pp_reduce_stage #(
  parameter int DW = 8,
  parameter bit EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vi,
  input  logic [DW-1:0] di,
  input  logic          rdy_nxt,
  output logic          vo,
  output logic [DW-1:0] dq,
  output logic          rdy
);
  if (EN) begin : g_reg
    logic          v_q;
    logic [DW-1:0] d_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (rdy) begin
        v_q <= vi;
        if (vi) d_q <= di;
      end
    end
    // A bubble accepts new data even while downstream is stalled.
    assign rdy = !v_q || rdy_nxt;
    assign vo  = v_q;
    assign dq  = d_q;
  end else begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign rdy = rdy_nxt;
    assign vo  = vi;
    assign dq  = di;
  end
endmodule

module pp_reduce_pipe #(
  parameter int         W         = 64,
  parameter int         TAG_W     = 4,
  parameter logic [3:0] PIPE_MASK = 4'b0101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17*W-1:0]  in_pp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [W-1:0]     out_carry,
  output logic [TAG_W-1:0] out_tag
`ifdef PP_REDUCE_CPA_EN
  ,
  output logic [W-1:0]     out_prod
`endif
);
  localparam int DW0 = TAG_W + 9*W;
  localparam int DW1 = TAG_W + 8*W;
  localparam int DW2 = TAG_W + 4*W;
  localparam int DW3 = TAG_W + 2*W;

  // Carry rows are kept unshifted (weight <<1) and shifted where consumed.
  logic [8:0][W-1:0] l0_o, l1_i;
  logic [7:0][W-1:0] l1_o, l2_i;
  logic [3:0][W-1:0] l2_o, l3_i;
  logic [1:0][W-1:0] l3_o, fin;
  logic [TAG_W-1:0]  t1, t2, t3, t4;
  logic              v1, v2, v3, v4;
  logic              r1, r2, r3, r4;
  logic [DW0-1:0]    q0;
  logic [DW1-1:0]    q1;
  logic [DW2-1:0]    q2;
  logic [DW3-1:0]    q3;

  // Level 0: four 4:2 groups over P0..P15, P16 rides along.
  for (genvar j = 0; j < 4; j++) begin : g_l0
    pp_reduce_c42 #(.W(W)) u_c42 (
      .a(in_pp[(4*j)*W +: W]), .b(in_pp[(4*j+1)*W +: W]),
      .c(in_pp[(4*j+2)*W +: W]), .d(in_pp[(4*j+3)*W +: W]),
      .sum(l0_o[2*j]), .carry(l0_o[2*j+1])
    );
  end
  assign l0_o[8] = in_pp[16*W +: W];

  pp_reduce_stage #(.DW(DW0), .EN(PIPE_MASK[0])) u_s0 (
    .clk(clk), .rst(rst), .vi(in_valid), .di({in_tag, l0_o}),
    .rdy_nxt(r1), .vo(v1), .dq(q0), .rdy(in_ready)
  );
  assign {t1, l1_i} = q0;

  // Level 1: 3:2 merge of P16 into the first group's pair.
  logic [W-1:0] m_x, m_y, m_z;
  assign m_x = l1_i[0];
  assign m_y = l1_i[1] << 1;
  assign m_z = l1_i[8];
  assign l1_o[0]   = m_x ^ m_y ^ m_z;
  assign l1_o[1]   = (m_x & m_y) | (m_x & m_z) | (m_y & m_z);
  assign l1_o[7:2] = l1_i[7:2];

  pp_reduce_stage #(.DW(DW1), .EN(PIPE_MASK[1])) u_s1 (
    .clk(clk), .rst(rst), .vi(v1), .di({t1, l1_o}),
    .rdy_nxt(r2), .vo(v2), .dq(q1), .rdy(r1)
  );
  assign {t2, l2_i} = q1;

  // Level 2: two 4:2 cells.
  for (genvar j = 0; j < 2; j++) begin : g_l2
    pp_reduce_c42 #(.W(W)) u_c42 (
      .a(l2_i[4*j]), .b(l2_i[4*j+1] << 1), .c(l2_i[4*j+2]), .d(l2_i[4*j+3] << 1),
      .sum(l2_o[2*j]), .carry(l2_o[2*j+1])
    );
  end

  pp_reduce_stage #(.DW(DW2), .EN(PIPE_MASK[2])) u_s2 (
    .clk(clk), .rst(rst), .vi(v2), .di({t2, l2_o}),
    .rdy_nxt(r3), .vo(v3), .dq(q2), .rdy(r2)
  );
  assign {t3, l3_i} = q2;

  // Level 3: final 4:2.
  pp_reduce_c42 #(.W(W)) u_l3 (
    .a(l3_i[0]), .b(l3_i[1] << 1), .c(l3_i[2]), .d(l3_i[3] << 1),
    .sum(l3_o[0]), .carry(l3_o[1])
  );

  pp_reduce_stage #(.DW(DW3), .EN(PIPE_MASK[3])) u_s3 (
    .clk(clk), .rst(rst), .vi(v3), .di({t3, l3_o}),
    .rdy_nxt(r4), .vo(v4), .dq(q3), .rdy(r3)
  );
  assign {t4, fin} = q3;

`ifdef PP_REDUCE_CPA_EN
  logic [W-1:0]             prod_i;
  logic [TAG_W+3*W-1:0]     qc;
  assign prod_i = fin[0] + (fin[1] << 1);

  pp_reduce_stage #(.DW(TAG_W+3*W), .EN(1'b1)) u_cpa (
    .clk(clk), .rst(rst), .vi(v4), .di({t4, prod_i, fin[1], fin[0]}),
    .rdy_nxt(out_ready), .vo(out_valid), .dq(qc), .rdy(r4)
  );
  assign {out_tag, out_prod, out_carry, out_sum} = qc;
`else
  assign r4        = out_ready;
  assign out_valid = v4;
  assign out_sum   = fin[0];
  assign out_carry = fin[1];
  assign out_tag   = t4;
`endif
endmodule
